// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from WIDTH T flip-flop stages; each stage toggles when its bit must change.
// Optional feature: define TFF_MOD_COUNTER_UPDOWN_EN to make the `up` direction input functional.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("tff_mod_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  // One extra bit keeps MODULUS = 2**WIDTH from truncating the compare values.
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   step_up;
  logic [WIDTH:0]   nxt_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             in_range;
  logic             unused_nxt_msb;

  assign q_ext    = {1'b0, q};
  assign d_ext    = {1'b0, d};
  assign at_max   = (q_ext == MAX);
  assign in_range = (q_ext <= MAX);
  assign step_up  = at_max ? '0 : q_ext + 1'b1;

`ifdef TFF_MOD_COUNTER_UPDOWN_EN
  logic [WIDTH:0] step_dn;
  logic           at_zero;

  assign at_zero = (q_ext == '0);
  assign step_dn = at_zero ? MAX : q_ext - 1'b1;
  assign tc      = en & ~load & (up ? at_max : at_zero);
`else
  logic unused_up;

  assign unused_up = up;
  assign tc        = en & ~load & at_max;
`endif

  always_comb begin
    nxt_ext = q_ext;
    if (load) begin
      nxt_ext = (d_ext > MAX) ? MAX : d_ext;
    end else if (en) begin
      // An out-of-range state can only come from corruption; recover to zero.
      if (!in_range) begin
        nxt_ext = '0;
      end else begin
`ifdef TFF_MOD_COUNTER_UPDOWN_EN
        nxt_ext = up ? step_up : step_dn;
`else
        nxt_ext = step_up;
`endif
      end
    end
  end

  assign nxt            = nxt_ext[WIDTH-1:0];
  assign unused_nxt_msb = nxt_ext[WIDTH];
  assign t              = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= 1'b0;
      end else if (t[i]) begin
        stage_q <= ~stage_q;
      end
    end

    assign q[i]  = stage_q;
    assign q_[i] = ~stage_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: doc/tff_mod_counter.md
# tff_mod_counter

Synchronous modulo-N up/down counter whose state bits are held in WIDTH `tff` stages. It sits directly downstream of the T flip-flop: the block computes each stage's toggle input from the current count, enable, load and direction, and consumes the flip-flop outputs as the count. It serves as the standard divider/event counter in the flip-flop library, with terminal-count and wrap outputs for cascading.

## Interface
- `WIDTH`, 4, number of T flip-flop stages (count bits); legal 1..16.
- `MODULUS`, 10, count range 0..MODULUS-1; legal 2..2^WIDTH.
- `clk`  in  1  rising-edge clock shared by all stages.
- `rst`  in  1  asynchronous, active-high reset; clears every stage.
- `en`  in  1  count enable; one step per clock while high.
- `load`  in  1  synchronous parallel load of `d`; overrides `en`.
- `d`  in  WIDTH  load value.
- `up`  in  1  direction: 1 = up, 0 = down (see Configuration).
- `q`  out  WIDTH  current count (stage `q` outputs).
- `q_`  out  WIDTH  bitwise complement of `q` (stage `q_` outputs).
- `tc`  out  1  terminal count, combinational.
- `wrap`  out  1  registered one-cycle pulse after a wrap step.

## Operation
- State exists only in the WIDTH `tff` stages; no other count register.
- Next value `nxt` chosen per clock, priority order: `load` > `en` > hold.
- Load: `nxt = d` if `d <= MODULUS-1`, else `nxt = MODULUS-1` (saturate).
- Count up: `nxt = (q == MODULUS-1) ? 0 : q + 1`.
- Count down: `nxt = (q == 0) ? MODULUS-1 : q - 1`.
- Hold: `nxt = q`.
- Stage toggle input: `t[i] = q[i] ^ nxt[i]`; hold therefore drives all t to 0.
- Arithmetic done in WIDTH+1 bits internally; no truncation on MODULUS = 2^WIDTH.
- `tc = en & ~load & (up ? q == MODULUS-1 : q == 0)`.
- `wrap` register set to `tc` each clock; high exactly in the cycle after a wrapping step. Load never produces `wrap`.
- If state is ever outside 0..MODULUS-1 (only possible via X-injection), next count step goes to 0 regardless of direction.
- Illegal parameters: elaboration-time error.

## Timing
- Reset (async, immediate, independent of `clk`): `q = 0`, `q_ = all ones`, `wrap = 0`; `tc = 0` if `up = 1`, else equals `en & ~load`.
- Reset deassertion: first count step on the first rising edge with `rst` low and `en` high.
- Reset asserted mid-count or mid-load: count abandoned, outputs as above, no `wrap` pulse.
- Latency: `q` reflects load/step one clock after the edge at which `load`/`en` sampled high.
- `tc` is same-cycle combinational from `q`, `en`, `load`, `up`; `wrap` trails it by one clock.
- `load` and `en` high together: load wins, `tc = 0`, no wrap.
- Direction change takes effect on the next edge; no dead cycle.
- Cascading: `tc` of stage k drives `en` of stage k+1; all on the same `clk`.

## Configuration
- `TFF_MOD_COUNTER_UPDOWN_EN` defined: `up` port functional as above.
- Not defined: `up` port present but ignored; counter always counts up; `tc = en & ~load & (q == MODULUS-1)`; down-count logic absent from the netlist.

## Test plan
- Defaults, `rst` pulse then `en=1` for 12 clocks -> `q` 0,1..9,0,1; `tc=1` only while `q=9`; `wrap=1` only in the cycle `q=0` after 9.
- `q=5`, `load=1 en=1 d=7` -> `q=7` next clock, `tc=0`, `wrap` stays 0.
- `load=1 d=12` (MODULUS=10) -> `q=9`, `q_=4'b0110`.
- Macro defined, `up=0 en=1` from `q=1` -> 0, 9, 8; `tc=1` at `q=0`, `wrap=1` in the cycle `q=9`. Macro undefined, same stimulus -> 2, 3, 4.
- Assert `rst` between edges while `q=6` -> `q=0`, `q_=4'b1111`, `wrap=0` immediately, before the next `clk` edge.
- WIDTH=3, MODULUS=8, `en=1` 9 clocks -> 0..7,0; `en=0` 3 clocks -> `q` holds, all stage toggles 0.
